// File: rtl/dominant_ctrl.sv
// Sequencing FSM for the dominant-eigenvector power-iteration datapath.
// Optional per-wait-state watchdog is enabled by defining DOM_CTRL_WATCHDOG_EN.
module dominant_ctrl #(
    parameter int unsigned MAX_ITER  = 32,
    parameter int unsigned ITER_W    = 6,
    parameter int unsigned WD_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [15:0]       tol_i,
    input  logic [15:0]       max_d_i,
    input  logic              mul_done_i,
    input  logic              scale_done_i,
    input  logic              diff_done_i,
    output logic              start_mult_o,
    output logic              load_y_o,
    output logic              start_scale_o,
    output logic              start_diff_o,
    output logic              load_max_d_o,
    output logic              load_v_old_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              converged_o,
    output logic              error_o,
    output logic [ITER_W-1:0] iter_count_o
);

    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StMult      = 4'd1;
    localparam logic [3:0] StWaitMult  = 4'd2;
    localparam logic [3:0] StLoadY     = 4'd3;
    localparam logic [3:0] StScale     = 4'd4;
    localparam logic [3:0] StWaitScale = 4'd5;
    localparam logic [3:0] StDiff      = 4'd6;
    localparam logic [3:0] StWaitDiff  = 4'd7;
    localparam logic [3:0] StLoadD     = 4'd8;
    localparam logic [3:0] StCheck     = 4'd9;
    localparam logic [3:0] StCommit    = 4'd10;
    localparam logic [3:0] StFinish    = 4'd11;

    logic [3:0]        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              conv_q, conv_d;
    logic              converged_q, converged_d;
    logic [15:0]       max_d_mag;
    logic              accept_start;
    logic              wd_expired;
    logic              wd_trip;

    // Two's-complement magnitude; -32768 maps to 32768 and so never passes a tol below it.
    assign max_d_mag    = max_d_i[15] ? (~max_d_i + 16'd1) : max_d_i;
    assign accept_start = (state_q == StIdle) && start_i;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        converged_d = converged_q;
        wd_trip     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StMult;
                    iter_d      = '0;
                    conv_d      = 1'b0;
                    converged_d = 1'b0;
                end
            end
            StMult:  state_d = StWaitMult;
            StWaitMult: begin
                if (mul_done_i) begin
                    state_d = StLoadY;
                end else if (wd_expired) begin
                    state_d = StFinish;
                    wd_trip = 1'b1;
                end
            end
            StLoadY: state_d = StScale;
            StScale: state_d = StWaitScale;
            StWaitScale: begin
                if (scale_done_i) begin
                    state_d = StDiff;
                end else if (wd_expired) begin
                    state_d = StFinish;
                    wd_trip = 1'b1;
                end
            end
            StDiff:  state_d = StWaitDiff;
            StWaitDiff: begin
                if (diff_done_i) begin
                    state_d = StLoadD;
                end else if (wd_expired) begin
                    state_d = StFinish;
                    wd_trip = 1'b1;
                end
            end
            StLoadD: state_d = StCheck;
            StCheck: begin
                // First iteration compares against an uninitialised v_old, so it never converges.
                iter_d  = iter_q + 1'b1;
                conv_d  = (iter_q != '0) && (max_d_mag <= tol_i);
                state_d = StCommit;
            end
            StCommit: begin
                if (conv_q) begin
                    converged_d = 1'b1;
                    state_d     = StFinish;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    state_d = StFinish;
                end else begin
                    state_d = StMult;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            iter_q      <= '0;
            conv_q      <= 1'b0;
            converged_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            converged_q <= converged_d;
        end
    end

`ifdef DOM_CTRL_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WD_CYCLES + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           error_q;
    logic           in_wait;

    assign in_wait    = (state_q == StWaitMult) || (state_q == StWaitScale) ||
                        (state_q == StWaitDiff);
    // Counts cycles already spent in the current wait state.
    assign wd_expired = in_wait && (wd_q == WdW'(WD_CYCLES - 1));
    assign wd_d       = in_wait ? (wd_q + 1'b1) : '0;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (accept_start) begin
                error_q <= 1'b0;
            end else if (wd_trip) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_o = error_q;
`else
    logic unused_wd;

    assign wd_expired = 1'b0;
    assign error_o    = 1'b0;
    assign unused_wd  = wd_trip | accept_start | (WD_CYCLES != 0);
`endif

    assign start_mult_o  = (state_q == StMult);
    assign load_y_o      = (state_q == StLoadY);
    assign start_scale_o = (state_q == StScale);
    assign start_diff_o  = (state_q == StDiff);
    assign load_max_d_o  = (state_q == StLoadD);
    assign load_v_old_o  = (state_q == StCommit);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StFinish);
    assign converged_o   = converged_q;
    assign iter_count_o  = iter_q;

endmodule

// File: tb/tb_dominant_ctrl.sv
// Self-checking bench for dominant_ctrl: vector table of runs plus hand-written corner cases.
// Built with DOM_CTRL_WATCHDOG_EN, the stuck-multiply case expects a watchdog error instead.
module tb_dominant_ctrl;

    localparam int unsigned MaxIter = 4;
    localparam int unsigned IterW   = 6;
    localparam int unsigned WdCyc   = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [15:0]      tol;
    logic [15:0]      max_d;
    logic             mul_done, scale_done, diff_done;
    logic             start_mult, load_y, start_scale, start_diff, load_max_d, load_v_old;
    logic             busy, done, converged, error;
    logic [IterW-1:0] iter_count;

    dominant_ctrl #(
        .MAX_ITER  (MaxIter),
        .ITER_W    (IterW),
        .WD_CYCLES (WdCyc)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .start_i       (start),
        .tol_i         (tol),
        .max_d_i       (max_d),
        .mul_done_i    (mul_done),
        .scale_done_i  (scale_done),
        .diff_done_i   (diff_done),
        .start_mult_o  (start_mult),
        .load_y_o      (load_y),
        .start_scale_o (start_scale),
        .start_diff_o  (start_diff),
        .load_max_d_o  (load_max_d),
        .load_v_old_o  (load_v_old),
        .busy_o        (busy),
        .done_o        (done),
        .converged_o   (converged),
        .error_o       (error),
        .iter_count_o  (iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       tol;
        logic [3:0][15:0]  md;      // max_d for iterations 1..4 (index 0 = iteration 1)
        int                exp_conv;
        int                exp_iter;
        int                exp_cyc; // cycles from start edge to done pulse
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Datapath model: each done follows its strobe by one cycle, max_d served per iteration.
    logic [3:0][15:0] md_tab;
    int  ld_idx = 0;
    bit  mul_en = 1'b1, scale_en = 1'b1;
    bit  mul_seen = 1'b0, scale_seen = 1'b0, diff_seen = 1'b0;
    int  n_mult, n_y, n_scale, n_diff, n_ld, n_vold;
    int  viol = 0;

    always @(negedge clk) begin
        if (mul_en) mul_done = mul_seen;
        mul_seen   = start_mult;
        scale_done = scale_seen && scale_en;
        scale_seen = start_scale;
        diff_done  = diff_seen;
        diff_seen  = start_diff;
        if (load_max_d) begin
            max_d = md_tab[ld_idx];
            if (ld_idx < 3) ld_idx++;
        end
        n_mult  += int'(start_mult);
        n_y     += int'(load_y);
        n_scale += int'(start_scale);
        n_diff  += int'(start_diff);
        n_ld    += int'(load_max_d);
        n_vold  += int'(load_v_old);
        if (int'(start_mult) + int'(load_y) + int'(start_scale) + int'(start_diff) +
            int'(load_max_d) + int'(load_v_old) > 1) viol++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_mult = 0; n_y = 0; n_scale = 0; n_diff = 0; n_ld = 0; n_vold = 0;
    endtask

    // Starts a run at a negedge and returns the cycle index of the done pulse (0 on timeout).
    task automatic run_until_done(input bit hold, output int cyc);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
        end while (!done && cyc < 300);
        if (!done) cyc = 0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit hold);
        int cyc;
        md_tab = v.md;
        ld_idx = 0;
        tol    = v.tol;
        clr_counts();
        run_until_done(hold, cyc);
        check({tag, " cycles"}, cyc, v.exp_cyc);
        check({tag, " converged"}, int'(converged), v.exp_conv);
        check({tag, " iter_count"}, int'(iter_count), v.exp_iter);
        check({tag, " error"}, int'(error), 0);
        check({tag, " n_start_mult"}, n_mult, v.exp_iter);
        check({tag, " n_load_y"}, n_y, v.exp_iter);
        check({tag, " n_start_scale"}, n_scale, v.exp_iter);
        check({tag, " n_start_diff"}, n_diff, v.exp_iter);
        check({tag, " n_load_max_d"}, n_ld, v.exp_iter);
        check({tag, " n_load_v_old"}, n_vold, v.exp_iter);
    endtask

    vec_t vecs[8];

    initial begin
        int cyc;
        vecs[0] = '{16'd2,      {16'd1, 16'd1, 16'd1, 16'd3},             1, 2, 21};
        vecs[1] = '{16'h0010,   {16'h0040, 16'h0040, 16'h0040, 16'h0040}, 0, 4, 41};
        vecs[2] = '{16'h7FFF,   {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 0, 4, 41};
        vecs[3] = '{16'd0,      {16'd0, 16'd0, 16'd0, 16'd0},             1, 2, 21};
        vecs[4] = '{16'd0,      {16'd1, 16'd1, 16'd1, 16'd5},             0, 4, 41};
        vecs[5] = '{16'd5,      {16'hFFFB, 16'hFFFB, 16'hFFFB, 16'd0},    1, 2, 21};
        vecs[6] = '{16'd4,      {16'hFFFB, 16'hFFFB, 16'hFFFB, 16'd0},    0, 4, 41};
        vecs[7] = '{16'h0008,   {16'h0002, 16'h0009, 16'h0020, 16'h0000}, 1, 4, 41};

        reset_n = 1'b0; start = 1'b0; tol = '0; max_d = '0;
        mul_done = 1'b0; scale_done = 1'b0; diff_done = 1'b0;
        clr_counts();
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset strobes", int'({start_mult, load_y, start_scale, start_diff,
                                     load_max_d, load_v_old}), 0);
        check("reset converged", int'(converged), 0);
        check("reset error", int'(error), 0);
        check("reset iter_count", int'(iter_count), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d busy after done", i), int'(busy), 0);
            check($sformatf("vec%0d converged held", i), int'(converged), vecs[i].exp_conv);
            check($sformatf("vec%0d iter held", i), int'(iter_count), vecs[i].exp_iter);
        end

        // start held high: restart only from IDLE, one cycle after done.
        run_vec("held", vecs[0], 1'b1);
        ld_idx = 0;
        @(negedge clk);
        check("held idle after done", int'(busy), 0);
        @(negedge clk);
        check("held restart start_mult", int'(start_mult), 1);
        check("held restart iter cleared", int'(iter_count), 0);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("held second run done", int'(done), 1);
        check("held second run iter", int'(iter_count), 2);
        check("held second run converged", int'(converged), 1);

        // mul_done only during the start_mult cycle must be ignored.
        @(negedge clk);
        mul_en = 1'b0;
        mul_done = 1'b0;
        clr_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignore mul strobe cycle", int'(start_mult), 1);
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
`ifdef DOM_CTRL_WATCHDOG_EN
        cyc = 2;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("watchdog done cycle", cyc, 10);
        check("watchdog error", int'(error), 1);
        check("watchdog converged", int'(converged), 0);
        check("watchdog no load_v_old", n_vold, 0);
        check("watchdog no load_y", n_y, 0);
`else
        repeat (20) @(negedge clk);
        check("stuck still busy", int'(busy), 1);
        check("stuck no load_y", n_y, 0);
        check("stuck no done", int'(done), 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif
        mul_en = 1'b1;
        @(negedge clk);

        // Asynchronous reset while waiting in WAIT_SCALE of iteration 2.
        md_tab = vecs[0].md;
        ld_idx = 0;
        tol    = vecs[0].tol;
        clr_counts();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (n_vold < 1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        scale_en = 1'b0;
        cyc = 0;
        while (!start_scale && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("midreset reached scale", int'(start_scale), 1);
        check("midreset iter before", int'(iter_count), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset strobes", int'({start_mult, load_y, start_scale, start_diff,
                                        load_max_d, load_v_old}), 0);
        check("midreset iter", int'(iter_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        scale_en = 1'b1;
        @(negedge clk);
        run_vec("after_reset", vecs[0], 1'b0);
        @(negedge clk);

        check("strobe overlap count", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
